f_im_loader: RTL and testbench

//  Writer side of the instruction memory: receives a program as a byte stream (valid/ready),

---
 rtl/f_im_loader_pkg.sv | 15 +
 rtl/f_im_loader_if.sv | 10 +
 rtl/f_im_loader_packer.sv | 35 +++
 rtl/f_im_loader.sv | 103 ++++++++++
 tb/tb_f_im_loader.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/f_im_loader_pkg.sv
// Shared instruction-memory constants and loader state encoding.
// Same base address and depth are used by the F stage and PC reset.
package f_im_loader_pkg;
  localparam int          IM_WORD_W    = 32;
  localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
  localparam int          IM_DEPTH     = 4096;
  localparam int          WORD_CNT_W   = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;
endpackage

// File: rtl/f_im_loader_if.sv
// Byte-stream link from the host/boot side into the IM loader.
interface f_im_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/f_im_loader_packer.sv
// im_word_packer: collects big-endian bytes into one 32-bit word.
module im_word_packer
  import f_im_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 push,
  input  logic [7:0]           byte_in,
  output logic                 word_full,
  output logic [IM_WORD_W-1:0] packed_word
);
  logic [1:0] idx_q;

  assign word_full = push && (idx_q == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q       <= 2'd0;
      packed_word <= '0;
    end else if (clr) begin
      idx_q       <= 2'd0;
      packed_word <= '0;
    end else if (push) begin
      idx_q <= idx_q + 2'd1;
      // first byte of a word lands in the MSB lane
      case (idx_q)
        2'd0:    packed_word[31:24] <= byte_in;
        2'd1:    packed_word[23:16] <= byte_in;
        2'd2:    packed_word[15:8]  <= byte_in;
        default: packed_word[7:0]   <= byte_in;
      endcase
    end
  end
endmodule

// File: rtl/f_im_loader.sv
// Instruction-memory loader: byte stream in, one IM word write per packed word.
// Optional checksum register enabled by F_IM_LOADER_CHECKSUM_EN.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start
// ST_RECV  | accepting bytes of the current word
// ST_WRITE | single-cycle IM write of the packed word
// ST_DONE  | program loaded, waiting for start
module f_im_loader
  import f_im_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IM_BASE_ADDR,
  parameter int          DEPTH     = IM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  f_im_loader_if.slave          bs,
  output logic                  im_we,
  output logic [31:0]           im_addr,
  output logic [IM_WORD_W-1:0]  im_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err_ovf,
  output logic [WORD_CNT_W-1:0] word_count,
  output logic [31:0]           checksum
);
  localparam logic [WORD_CNT_W-1:0] DEPTH_CNT = WORD_CNT_W'(DEPTH);

  loader_state_t        state_q, state_d;
  logic                 last_q;
  logic                 accept, word_full, go_write, at_cap, wr_fire;
  logic [IM_WORD_W-1:0] packed_word;

  assign bs.s_ready = (state_q == ST_RECV);
  assign accept     = bs.s_valid && bs.s_ready;
  assign go_write   = word_full || (accept && bs.s_last);
  assign at_cap     = (word_count == DEPTH_CNT);
  // start in the same cycle as WRITE aborts that write
  assign wr_fire    = (state_q == ST_WRITE) && !start && !at_cap;

  assign im_we    = wr_fire;
  assign im_addr  = BASE_ADDR + 32'({word_count, 2'b00});
  assign im_wdata = packed_word;
  assign busy     = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);

  im_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr         (start || (state_q == ST_WRITE)),
    .push        (accept && !start),
    .byte_in     (bs.s_data),
    .word_full   (word_full),
    .packed_word (packed_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_RECV:  if (go_write) state_d = ST_WRITE;
      ST_WRITE: state_d = last_q ? ST_DONE : ST_RECV;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (start) state_d = ST_RECV;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b0;
      word_count <= '0;
      err_ovf    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        last_q     <= 1'b0;
        word_count <= '0;
        err_ovf    <= 1'b0;
      end else begin
        if (state_q == ST_RECV && go_write) last_q <= bs.s_last;
        if (wr_fire) word_count <= word_count + 1'b1;
        if (state_q == ST_WRITE && at_cap) err_ovf <= 1'b1;
      end
    end
  end

`ifdef F_IM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       checksum_q <= '0;
    else if (start)   checksum_q <= '0;
    else if (wr_fire) checksum_q <= checksum_q ^ packed_word;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif
endmodule

// File: tb/tb_f_im_loader.sv
// Self-checking bench for f_im_loader: directed programs, abort/reset cases, random programs.
module tb_f_im_loader;
  import f_im_loader_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        im_we, busy, done, err_ovf;
  logic [31:0] im_addr, im_wdata, checksum;
  logic [12:0] word_count;

  f_im_loader_if bus ();

  f_im_loader #(.BASE_ADDR(IM_BASE_ADDR), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bs         (bus.slave),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .busy       (busy),
    .done       (done),
    .err_ovf    (err_ovf),
    .word_count (word_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] wr_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_q.push_back({im_addr, im_wdata});
      check_eq("ready_in_write", {31'b0, bus.s_ready}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    bus.s_last  = last;
    while (!bus.s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Reference: the program is cut into 4-byte big-endian words (zero padded),
  // the first DEPTH of them land at consecutive word addresses from the base.
  task automatic run_prog(input string tag, input logic [7:0] prog[$], input bit gaps);
    int n, nw, nwr, k;
    logic [31:0] w, cks, exp_cks;
    logic [63:0] e;
    n   = prog.size();
    nw  = (n + 3) / 4;
    nwr = (nw < DEPTH) ? nw : DEPTH;
    cks = 32'h0;
    do_start();
    wr_q.delete();
    check_eq({tag, "_wc0"},   32'(word_count), 32'd0);
    check_eq({tag, "_cks0"},  checksum, 32'd0);
    check_eq({tag, "_busy0"}, {31'b0, busy}, 32'd1);
    for (int i = 0; i < n; i++) send_byte(prog[i], i == n - 1, gaps);
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq({tag, "_done"}, {31'b0, done}, 32'd1);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_nwr"}, 32'(wr_q.size()), 32'(nwr));
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++)
        if (4 * i + j < n) w = w | (32'(prog[4 * i + j]) << (24 - 8 * j));
      if (i < nwr) begin
        cks = cks ^ w;
        e = (i < wr_q.size()) ? wr_q[i] : 64'hx;
        check_eq({tag, "_addr"}, e[63:32], IM_BASE_ADDR + 32'(4 * i));
        check_eq({tag, "_data"}, e[31:0], w);
      end
    end
    check_eq({tag, "_wc"},  32'(word_count), 32'(nwr));
    check_eq({tag, "_ovf"}, {31'b0, err_ovf}, {31'b0, (nw > DEPTH)});
`ifdef F_IM_LOADER_CHECKSUM_EN
    exp_cks = cks;
`else
    exp_cks = 32'h0;
`endif
    check_eq({tag, "_cks"}, checksum, exp_cks);
  endtask

  initial begin
    logic [7:0] q[$];
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'b0, bus.s_ready}, 32'd0);
    check_eq("rst_we",    {31'b0, im_we}, 32'd0);
    check_eq("rst_busy",  {31'b0, busy}, 32'd0);
    check_eq("rst_done",  {31'b0, done}, 32'd0);
    check_eq("rst_ovf",   {31'b0, err_ovf}, 32'd0);
    check_eq("rst_addr",  im_addr, 32'h0000_3000);
    check_eq("rst_wdata", im_wdata, 32'd0);
    check_eq("rst_wc",    32'(word_count), 32'd0);
    check_eq("rst_cks",   checksum, 32'd0);
    reset = 1'b1;

    // bytes offered while idle must not be consumed
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    repeat (3) begin @(posedge clk); #1; end
    bus.s_valid = 1'b0;
    check_eq("idle_ready", {31'b0, bus.s_ready}, 32'd0);
    check_eq("idle_nwr",   32'(wr_q.size()), 32'd0);

    q = {8'h20, 8'h08, 8'h00, 8'h05};
    run_prog("t1", q, 1'b0);
    q = {8'h3C, 8'h01, 8'h00, 8'h00, 8'h34, 8'h21, 8'h00, 8'h10};
    run_prog("t2", q, 1'b1);
`ifdef F_IM_LOADER_CHECKSUM_EN
    check_eq("t2_cks_ref", checksum, 32'h0820_0010);
`endif
    q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_prog("t3", q, 1'b0);
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'(i * 7 + 1));
    run_prog("t4", q, 1'b1);

    // abort mid-word: 2 full words + 2 bytes, then a fresh load restarts at the base
    do_start();
    wr_q.delete();
    for (int i = 0; i < 10; i++) send_byte(8'(8'hC0 + i), 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("abort_nwr", 32'(wr_q.size()), 32'd2);
    check_eq("abort_wc",  32'(word_count), 32'd2);
    q = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    run_prog("t5", q, 1'b0);

    // reset asserted during a WRITE cycle
    do_start();
    for (int i = 0; i < 4; i++) send_byte(8'(8'hE0 + i), 1'b0, 1'b0);
    check_eq("mid_we",    {31'b0, im_we}, 32'd1);
    check_eq("mid_wdata", im_wdata, 32'hE0E1_E2E3);
    reset = 1'b0;
    #1;
    check_eq("mid_we_drop", {31'b0, im_we}, 32'd0);
    check_eq("mid_busy",    {31'b0, busy}, 32'd0);
    check_eq("mid_wdata0",  im_wdata, 32'd0);
    @(posedge clk); #1;
    check_eq("mid_addr", im_addr, 32'h0000_3000);
    check_eq("mid_wc",   32'(word_count), 32'd0);
    reset = 1'b1;

    for (int t = 0; t < 25; t++) begin
      q.delete();
      repeat ($urandom_range(1, 24)) q.push_back(8'($urandom));
      run_prog($sformatf("rnd%0d", t), q, ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
